// File: rtl/toom_8_recompose.sv
// Toom-8 recomposition: overlap-adds 15 signed coefficients at a LIMB_W stride into a product.
// Optional macro TOOM8_RECOMP_OVF_EN enables the sticky out-of-range flag on ovf.
module toom_8_recompose #(
    parameter int unsigned LIMB_W = 128,
    parameter int unsigned NCOEF  = 15,
    parameter int unsigned COEF_W = 320,
    parameter int unsigned PROD_W = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic [3:0]        coef_idx,
    output logic              ovf
);

    localparam int unsigned ACC_W    = PROD_W + COEF_W;
    localparam int unsigned SH_W     = $clog2(ACC_W);
    localparam logic [3:0]  LAST_IDX = 4'(NCOEF - 1);

    typedef enum logic [0:0] {StAccum, StOut} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   coef_ext, coef_sh;
    logic [SH_W-1:0]    shamt;
    logic [3:0]         coef_idx_q, coef_idx_d;
    logic               accept, last, done;

    assign accept = in_valid && in_ready;
    assign last   = (coef_idx_q == LAST_IDX);
    assign done   = out_valid && out_ready;

    // Sign-extend to the full accumulator so negative coefficients borrow correctly.
    always_comb begin
        coef_ext = {{(ACC_W - COEF_W){in_coef[COEF_W-1]}}, in_coef};
        shamt    = SH_W'(LIMB_W * 32'(coef_idx_q));
        coef_sh  = coef_ext << shamt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (accept && last) state_d = StOut;
            StOut:   if (out_ready)      state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAccum: in_ready  = 1'b1;
            StOut:   out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Accumulator and index; the index parks on the last coefficient while the product is held.
    always_comb begin
        acc_d      = acc_q;
        coef_idx_d = coef_idx_q;
        if (accept) begin
            acc_d = acc_q + coef_sh;
            if (!last) coef_idx_d = coef_idx_q + 4'd1;
        end else if (done) begin
            acc_d      = '0;
            coef_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            coef_idx_q <= '0;
        end else begin
            acc_q      <= acc_d;
            coef_idx_q <= coef_idx_d;
        end
    end

    assign product  = acc_q[PROD_W-1:0];
    assign coef_idx = coef_idx_q;

`ifdef TOOM8_RECOMP_OVF_EN
    logic ovf_q, ovf_d;

    // Any bit above the product means the true sum is negative or too large.
    always_comb begin
        ovf_d = ovf_q;
        if (accept && last) begin
            ovf_d = |acc_d[ACC_W-1:PROD_W];
        end else if (done) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_toom_8_recompose.sv
// Scoreboard bench for toom_8_recompose: directed coefficient streams with hand-computed products.
module tb_toom_8_recompose;

    localparam int unsigned COEF_W = 320;
    localparam int unsigned PROD_W = 2048;
    localparam int unsigned NCOEF  = 15;

    typedef struct packed {
        logic [PROD_W-1:0] p;
        logic              o;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic [3:0]        coef_idx;
    logic              ovf;

    exp_t              sb_q[$];
    logic [COEF_W-1:0] coefs[NCOEF];
    int                n_tests = 0;
    int                n_fail  = 0;

    toom_8_recompose dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .coef_idx  (coef_idx),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PROD_W-1:0] act,
                       input logic [PROD_W-1:0] exp);
        int first;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            first = -1;
            for (int b = 0; b < int'(PROD_W); b++) begin
                if (first < 0 && act[b] !== exp[b]) first = b;
            end
            $display("FAIL %s: got[63:0]=%h required[63:0]=%h first differing bit %0d",
                     name, act[63:0], exp[63:0], first);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_product: got[63:0]=%h required none", product[63:0]);
            end else begin
                e = sb_q.pop_front();
                chk("product", product, e.p);
                chk("ovf", PROD_W'(ovf), PROD_W'(e.o));
            end
        end
    end

    task automatic send(input logic [COEF_W-1:0] c);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_coef  = c;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_coef  = '0;
    endtask

    task automatic run_product(input logic [PROD_W-1:0] exp_p, input logic exp_o,
                               input int gap_max);
        exp_t e;
        e.p = exp_p;
        e.o = exp_o;
        sb_q.push_back(e);
        for (int i = 0; i < int'(NCOEF); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
            send(coefs[i]);
        end
        chk("latency_out_valid", PROD_W'(out_valid), PROD_W'(1));
        chk("latency_in_ready", PROD_W'(in_ready), PROD_W'(0));
    endtask

    task automatic clear_coefs();
        for (int i = 0; i < int'(NCOEF); i++) coefs[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PROD_W-1:0] ep;
        logic              ovf_exp;
        bit                drained;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", PROD_W'(out_valid), PROD_W'(0));
        chk("rst_in_ready", PROD_W'(in_ready), PROD_W'(1));
        chk("rst_coef_idx", PROD_W'(coef_idx), PROD_W'(0));
        chk("rst_product", product, '0);
        chk("rst_ovf", PROD_W'(ovf), PROD_W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single top limb: only bit 1792.
        clear_coefs();
        coefs[14] = COEF_W'(1);
        ep = '0;
        ep[1792] = 1'b1;
        run_product(ep, 1'b0, 0);

        // All ones with random idle gaps.
        for (int i = 0; i < int'(NCOEF); i++) coefs[i] = COEF_W'(1);
        ep = '0;
        for (int i = 0; i < int'(NCOEF); i++) ep[128*i] = 1'b1;
        run_product(ep, 1'b0, 2);

        // Negative borrow: -1 + 2^128.
        clear_coefs();
        coefs[0] = '1;
        coefs[1] = COEF_W'(1);
        ep = '0;
        ep[127:0] = '1;
        run_product(ep, 1'b0, 1);

        // Overflow: 2^256 * 2^1792 lands entirely above the product.
        clear_coefs();
        coefs[14][256] = 1'b1;
`ifdef TOOM8_RECOMP_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        run_product('0, ovf_exp, 0);

        // Backpressure: product held while out_ready is low.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        clear_coefs();
        coefs[0] = COEF_W'(7);
        run_product(PROD_W'(7), 1'b0, 0);
        in_valid = 1'b1;
        in_coef  = COEF_W'(9);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", PROD_W'(in_ready), PROD_W'(0));
            chk("bp_out_valid", PROD_W'(out_valid), PROD_W'(1));
            chk("bp_product", product, PROD_W'(7));
            chk("bp_coef_idx", PROD_W'(coef_idx), PROD_W'(14));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_coef_idx", PROD_W'(coef_idx), PROD_W'(0));
        chk("bp_release_in_ready", PROD_W'(in_ready), PROD_W'(1));
        chk("bp_release_out_valid", PROD_W'(out_valid), PROD_W'(0));
        @(posedge clk);
        #1;

        // Reset mid-product discards the partial sum.
        for (int i = 0; i < 7; i++) send(COEF_W'(5));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", PROD_W'(out_valid), PROD_W'(0));
        chk("midrst_coef_idx", PROD_W'(coef_idx), PROD_W'(0));
        chk("midrst_in_ready", PROD_W'(in_ready), PROD_W'(1));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_coefs();
        coefs[0] = COEF_W'(3);
        run_product(PROD_W'(3), 1'b0, 0);

        drained = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toom_8_recompose.md
# toom_8_recompose

Final stage of the Toom-8 1024×1024 multiplier. It accepts the 15 interpolated limb-product coefficients c0..c14, one per handshake, and overlap-adds each one at a 128-bit stride into a 2048-bit product. Evaluation splits X and Y into eight 128-bit limbs; this block joins the coefficient results back into one product. It sits between the interpolation unit and the multiplier's result port.

## Interface
Parameters:
- LIMB_W, 128, limb stride in bits; coefficient i is weighted by 2^(LIMB_W·i)
- NCOEF, 15, coefficients per product (c0..c14)
- COEF_W, 320, signed width of each incoming coefficient
- PROD_W, 2048, output product width (LIMB_W·16)

Ports:
- clk  in  1  single clock; all state is updated on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  coefficient on in_coef is valid
- in_ready  out  1  block can accept a coefficient this cycle
- in_coef  in  COEF_W  signed two's-complement coefficient c_i, sent in order i=0..14
- out_valid  out  1  product is valid
- out_ready  in  1  consumer accepts product
- product  out  PROD_W  result, equal to Σ c_i·2^(128i) mod 2^2048
- coef_idx  out  4  index of the next coefficient to be accepted (0..14)
- ovf  out  1  sticky overflow flag for the current product (see Configuration)

## Operation
- Internal accumulator acc is signed and ACC_W = PROD_W+COEF_W bits wide. It never wraps internally.
- Accept condition: in_valid && in_ready. On accept, acc <= acc + (sign_ext(in_coef) << (LIMB_W·coef_idx)), and coef_idx increments.
- Shifted bits that fall above ACC_W−1 are discarded. With the default parameters, c14 spans bits 1792..2111, which fits inside ACC_W.
- State machine:
  - ACCUM: in_ready=1, out_valid=0.
    - Each accept with coef_idx<14 stays in ACCUM.
    - The accept with coef_idx==14 moves to OUT.
  - OUT: in_ready=0, out_valid=1.
    - product = acc[PROD_W-1:0], held stable.
    - When out_ready=1, move to ACCUM with acc<=0, coef_idx<=0, ovf<=0.
- in_valid is ignored in OUT. There is no simultaneous accept-and-output in the same cycle.
- Coefficient order is fixed at c0 first. There is no out-of-order or index input.

## Timing
- Reset (asynchronous, immediate): state=ACCUM, acc=0, coef_idx=0, in_ready=1, out_valid=0, product=0, ovf=0.
- Reset deasserting mid-product discards partial work. The next accepted coefficient is treated as c0.
- Latency: out_valid rises on the edge that accepts c14, so it is visible the cycle after that accept.
- Throughput: minimum 16 cycles per product (15 accepts plus 1 output cycle, with out_ready tied high).
- Gaps in in_valid are allowed. acc and coef_idx hold during gaps.
- product and ovf are stable for the whole time out_valid=1, including while out_ready is held low.
- The single-cycle add is a full ACC_W-bit adder. No carry chain spans more than one cycle of state.

## Configuration
- TOOM8_RECOMP_OVF_EN defined:
  - At the transition to OUT, ovf is set to 1 if acc[ACC_W-1:PROD_W] is nonzero, i.e. the true sum is negative or ≥2^2048.
  - ovf holds with the product and clears on the output handshake.
- TOOM8_RECOMP_OVF_EN undefined:
  - The ovf port exists but is tied to 0, and no compare logic is synthesized.
  - product behaviour is identical in both builds.

## Test plan
- Single top limb: c14=1, all others 0 (X=Y=limb7 only, i.e. 2^896 each) -> product = 2^1792 (only bit 1792 set), ovf=0, out_valid on the cycle after the 15th accept.
- All ones: c0..c14=1 -> product = Σ_{i=0..14} 2^(128i), so bits 0,128,…,1792 are set.
- Negative borrow: c0=−1, c1=1, others 0 -> product = 2^128−1 (bits 127:0 set), ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, product and coef_idx unchanged. Then out_ready=1 -> coef_idx=0, in_ready=1 on the next cycle.
- Reset mid-product: accept c0..c6 with value 5, pulse rst_n low -> out_valid=0, coef_idx=0 immediately. A subsequent stream with c0=3, rest 0 -> product=3.
- Overflow: c14=2^256, others 0 -> ovf=1 with TOOM8_RECOMP_OVF_EN, ovf=0 without. product=0 in both builds.
